// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and helpers for the TX upconverter and RX downconverter.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// Holds the 32-bit arctan table, the phase width and a round-half-up shifter.
// Phase convention: a full 2^32 phase word spans one turn (2*pi).
package cordic_pkg;

  localparam int WP = 32;

  // atan(2^-n) * 2^32 / (2*pi), n = 0..31. Entry 0 is pi/4; the rotation
  // stages index this table directly by their shift amount.
  localparam logic [31:0] ATAN_TABLE [0:31] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

  // Arithmetic right shift by n, rounding half-up by adding back the last
  // bit shifted out. Callers sign-extend into 64 bits and truncate after.
  function automatic logic signed [63:0] rshift_rnd(input logic signed [63:0] v,
                                                    input int unsigned n);
    logic signed [63:0] r;
    r = v >>> n;
    if (n != 0) begin
      r = r + {63'd0, v[6'(n - 1)]};
    end
    return r;
  endfunction

  // Table entry n rescaled to an angle register of width wz whose LSB weighs
  // 2^(WP-wz+1) phase units, rounded to nearest.
  function automatic logic [31:0] atan_scaled(input int n, input int wz);
    logic [31:0] rnd_bit;
    rnd_bit = 32'd1 << (WP - wz);
    return (ATAN_TABLE[5'(n)] + rnd_bit) >> (WP - wz + 1);
  endfunction

endpackage

// File: rtl/cordic_rot_stage.sv
// One registered rotation-mode CORDIC iteration with shift SHIFT.
// Latency: 1 clock.
// Backpressure: none; advances every clock.
//
// Ports: clock; x_i/y_i/z_i current vector and residual angle;
//        x_o/y_o/z_o registered rotated vector and updated angle.
// LAST holds Z instead of updating it (nothing downstream consumes it).
module cordic_rot_stage
  import cordic_pkg::*;
#(
  parameter int               SHIFT = 0,
  parameter int               WR    = 22,
  parameter int               WZ    = 20,
  parameter logic [WZ-1:0]    ATAN  = '0,
  parameter bit               LAST  = 1'b0
) (
  input  logic                 clock,
  input  logic signed [WR-1:0] x_i,
  input  logic signed [WR-1:0] y_i,
  input  logic signed [WZ-1:0] z_i,
  output logic signed [WR-1:0] x_o,
  output logic signed [WR-1:0] y_o,
  output logic signed [WZ-1:0] z_o
);

  logic signed [WR-1:0] x_sh, y_sh;
  logic signed [WR-1:0] x_d, x_q, y_d, y_q;
  logic signed [WZ-1:0] z_d, z_q;
  logic                 z_neg;

  always_comb begin
    x_sh  = WR'(rshift_rnd(64'(x_i), SHIFT));
    y_sh  = WR'(rshift_rnd(64'(y_i), SHIFT));
    // d = -1 when the residual angle is negative, +1 otherwise.
    z_neg = z_i[WZ-1];
    if (z_neg) begin
      x_d = x_i + y_sh;
      y_d = y_i - x_sh;
      z_d = z_i + ATAN;
    end else begin
      x_d = x_i - y_sh;
      y_d = y_i + x_sh;
      z_d = z_i - ATAN;
    end
    if (LAST) begin
      z_d = z_i;
    end
  end

  // Datapath registers carry no reset; validity is tracked separately.
  always_ff @(posedge clock) begin
    x_q <= x_d;
    y_q <= y_d;
    z_q <= z_d;
  end

  assign x_o = x_q;
  assign y_o = y_q;
  assign z_o = z_q;

endmodule

// File: rtl/cordic_upconverter.sv
// TX mixer: rotates I/Q by an NCO phase with a pipelined CORDIC, outputs the real part.
// Latency: STG+2 clocks (20 with defaults), one sample per clock.
// Backpressure: none; in_valid is delayed to out_valid, consumers must keep up.
//
// Ports: clock, reset_n (async, active low); frequency = phase step per valid
//        sample; phase_clear restarts the NCO; in_valid/in_I/in_Q baseband in;
//        out_valid/out_data real output, out_data ~ (K/4)*(I*cos - Q*sin).
module cordic_upconverter
  import cordic_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int EXTRA_BITS = 4,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic        [WP-1:0]        frequency,
  input  logic                        phase_clear,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_I,
  input  logic signed [IN_WIDTH-1:0]  in_Q,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out_data
);

  localparam int WR  = IN_WIDTH + EXTRA_BITS + 2;
  localparam int STG = OUT_WIDTH + EXTRA_BITS - 2;
  localparam int WZ  = STG + 2;
  localparam int L   = STG + 2;
  localparam logic signed [WR-1:0] OUT_MAX = WR'((1 << (OUT_WIDTH - 1)) - 1);

  // ---------------- NCO ----------------
  logic [WP-1:0] phase_d, phase_q;

  always_comb begin
    if (phase_clear) begin
      phase_d = in_valid ? frequency : '0;
    end else if (in_valid) begin
      phase_d = phase_q + frequency;
    end else begin
      phase_d = phase_q;
    end
  end

  // ---------------- Stage 0: quadrant pre-rotation ----------------
  logic [1:0]           quad;
  logic [WZ-4:0]        resid;
  logic signed [WR-1:0] i_ext, q_ext;
  logic signed [WR-1:0] x0_d, y0_d, x0_q, y0_q;
  logic signed [WZ-1:0] z0_d, z0_q;

  always_comb begin
    // phase_clear rotates the current sample by zero.
    quad  = phase_clear ? 2'b00 : phase_q[WP-1:WP-2];
    resid = phase_clear ? '0    : phase_q[WP-3:WP-WZ+1];
    i_ext = {{2{in_I[IN_WIDTH-1]}}, in_I, {EXTRA_BITS{1'b0}}};
    q_ext = {{2{in_Q[IN_WIDTH-1]}}, in_Q, {EXTRA_BITS{1'b0}}};
    case (quad)
      2'd0:    begin x0_d = i_ext;  y0_d = q_ext;  end
      2'd1:    begin x0_d = -q_ext; y0_d = i_ext;  end
      2'd2:    begin x0_d = -i_ext; y0_d = -q_ext; end
      default: begin x0_d = q_ext;  y0_d = -i_ext; end
    endcase
    // Residual in [0, pi/2) lies inside the CORDIC convergence range.
    z0_d = {3'b000, resid};
  end

  always_ff @(posedge clock) begin
    x0_q <= x0_d;
    y0_q <= y0_d;
    z0_q <= z0_d;
  end

  // ---------------- Rotation stages ----------------
  logic signed [WR-1:0] xs [0:STG];
  logic signed [WR-1:0] ys [0:STG];
  logic signed [WZ-1:0] zs [0:STG];

  assign xs[0] = x0_q;
  assign ys[0] = y0_q;
  assign zs[0] = z0_q;

  for (genvar k = 0; k < STG; k++) begin : g_stage
    cordic_rot_stage #(
      .SHIFT (k),
      .WR    (WR),
      .WZ    (WZ),
      .ATAN  (WZ'(atan_scaled(k, WZ))),
      .LAST  (k == STG - 1)
    ) u_stage (
      .clock (clock),
      .x_i   (xs[k]),
      .y_i   (ys[k]),
      .z_i   (zs[k]),
      .x_o   (xs[k+1]),
      .y_o   (ys[k+1]),
      .z_o   (zs[k+1])
    );
  end

  // ---------------- Output rounding / saturation ----------------
  logic signed [WR-1:0]        x_rnd;
  logic signed [OUT_WIDTH-1:0] out_data_d, out_data_q;
  logic [L-1:0]                vld_sr_d, vld_sr_q;

  always_comb begin
    x_rnd = WR'(rshift_rnd(64'(xs[STG]), WR - OUT_WIDTH));
    // Symmetric clip: the most negative code is never emitted.
    if (x_rnd > OUT_MAX) begin
      out_data_d = OUT_MAX[OUT_WIDTH-1:0];
    end else if (x_rnd < -OUT_MAX) begin
      out_data_d = -OUT_MAX[OUT_WIDTH-1:0];
    end else begin
      out_data_d = x_rnd[OUT_WIDTH-1:0];
    end
    vld_sr_d = {vld_sr_q[L-2:0], in_valid};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q    <= '0;
      vld_sr_q   <= '0;
      out_data_q <= '0;
    end else begin
      phase_q    <= phase_d;
      vld_sr_q   <= vld_sr_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = vld_sr_q[L-1];
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_cordic_upconverter.sv
// Self-checking bench for cordic_upconverter against a real-valued mixer model.
// Latency: expects each valid sample 20 clocks later, checks out_valid every cycle.
// Backpressure: none; stimulus drives one step per clock.
module tb_cordic_upconverter;

  localparam int    L      = 20;
  localparam int    NITER  = 18;
  localparam real   PI     = 3.14159265358979323846;

  logic               clock = 1'b0;
  logic               reset_n;
  logic        [31:0] frequency;
  logic               phase_clear;
  logic               in_valid;
  logic signed [15:0] in_I, in_Q;
  logic               out_valid;
  logic signed [15:0] out_data;

  always #5 clock = ~clock;

  cordic_upconverter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .frequency   (frequency),
    .phase_clear (phase_clear),
    .in_valid    (in_valid),
    .in_I        (in_I),
    .in_Q        (in_Q),
    .out_valid   (out_valid),
    .out_data    (out_data)
  );

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  real kgain;
  logic [31:0] mphase = 32'd0;

  // Expected outputs in arrival order: due cycle, ideal value, tolerance.
  int  due_q [$];
  real val_q [$];
  int  tol_q [$];

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input real exp, input int tol);
    real  d;
    logic ok;
    d  = $itor(obs) - exp;
    if (d < 0.0) d = -d;
    ok = (d <= $itor(tol));
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0.2f tol=%0d (cycle %0d)", tag, obs, exp, tol, cyc);
    end
  endtask

  // One clock: apply inputs, update the model, then check the outputs.
  task automatic step(input logic v, input int i, input int q, input logic clr,
                      input logic [31:0] f, input int tol);
    logic [31:0] ph;
    real         phi, ref_val;
    in_valid    = v;
    in_I        = 16'(i);
    in_Q        = 16'(q);
    phase_clear = clr;
    frequency   = f;
    if (v) begin
      ph      = clr ? 32'd0 : mphase;
      phi     = $itor($signed(ph)) * 2.0 * PI / 4294967296.0;
      ref_val = kgain * ($itor(i) * $cos(phi) - $itor(q) * $sin(phi));
      if (ref_val > 32767.0)  ref_val = 32767.0;
      if (ref_val < -32767.0) ref_val = -32767.0;
      due_q.push_back(cyc + L);
      val_q.push_back(ref_val);
      tol_q.push_back(tol);
    end
    if (clr)    mphase = v ? f : 32'd0;
    else if (v) mphase = mphase + f;
    @(posedge clock);
    cyc++;
    #1;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      check_bit("out_valid", out_valid, 1'b1);
      check_near("out_data", int'(out_data), val_q[0], tol_q[0]);
      void'(due_q.pop_front());
      void'(val_q.pop_front());
      void'(tol_q.pop_front());
    end else begin
      check_bit("out_valid_idle", out_valid, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0, 32'd0, 3);
  endtask

  function automatic int rnd_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    real kg, p;
    kg = 1.0;
    p  = 1.0;
    for (int n = 0; n < NITER; n++) begin
      kg = kg * $sqrt(1.0 + p);
      p  = p / 4.0;
    end
    kgain = kg / 4.0;

    // Reset state.
    reset_n = 1'b0; in_valid = 1'b0; phase_clear = 1'b0;
    in_I = '0; in_Q = '0; frequency = '0;
    repeat (3) @(posedge clock);
    #1;
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_int("rst_out_data", int'(out_data), 0);
    reset_n = 1'b1;

    // Gain: phase 0, I = 16384 -> about 6745.
    step(1'b1, 16384, 0, 1'b1, 32'd0, 2);
    for (int k = 0; k < 29; k++) step(1'b1, 16384, 0, 1'b0, 32'd0, 2);
    idle(L + 2);

    // Quadrant cycling, real input then imaginary input.
    step(1'b1, 16384, 0, 1'b1, 32'h4000_0000, 2);
    for (int k = 0; k < 11; k++) step(1'b1, 16384, 0, 1'b0, 32'h4000_0000, 2);
    step(1'b1, 0, 16384, 1'b1, 32'h4000_0000, 2);
    for (int k = 0; k < 11; k++) step(1'b1, 0, 16384, 1'b0, 32'h4000_0000, 2);
    idle(L + 2);

    // Full scale at -45 degrees -> about 19078.
    step(1'b1, 32767, 32767, 1'b1, 32'hE000_0000, 3);
    for (int k = 0; k < 8; k++) step(1'b1, 32767, 32767, 1'b0, 32'd0, 3);
    idle(L + 2);

    // Single pulse, then the 1,0,0,1,1 pattern with a nonzero step.
    step(1'b1, 12000, -7000, 1'b1, 32'h1234_5678, 3);
    idle(L + 2);
    step(1'b1, 1000, -2000, 1'b0, 32'h1234_5678, 3);
    step(1'b0, 0, 0, 1'b0, 32'h1234_5678, 3);
    step(1'b0, 0, 0, 1'b0, 32'h1234_5678, 3);
    step(1'b1, -15000, 9000, 1'b0, 32'h1234_5678, 3);
    step(1'b1, 20000, 20000, 1'b0, 32'h1234_5678, 3);
    idle(L + 2);

    // Phase wrap with a near-half-turn step.
    step(1'b1, rnd_s16(), rnd_s16(), 1'b1, 32'h7FFF_FFFF, 3);
    for (int k = 0; k < 9; k++) step(1'b1, rnd_s16(), rnd_s16(), 1'b0, 32'h7FFF_FFFF, 3);
    idle(L + 2);

    // Random sweep: sparse valid, random I/Q/frequency, occasional clear.
    for (int k = 0; k < 300; k++) begin
      step(logic'($urandom_range(0, 3) != 0), rnd_s16(), rnd_s16(),
           logic'($urandom_range(0, 31) == 0), $urandom, 3);
    end
    idle(L + 2);

    // Reset while outputs are flowing.
    for (int k = 0; k < 25; k++) step(1'b1, rnd_s16(), rnd_s16(), 1'b0, 32'h0765_4321, 3);
    reset_n = 1'b0;
    in_valid = 1'b0;
    #2;
    check_bit("midrst_out_valid", out_valid, 1'b0);
    check_int("midrst_out_data", int'(out_data), 0);
    due_q.delete(); val_q.delete(); tol_q.delete();
    mphase = 32'd0;
    @(posedge clock);
    cyc++;
    #1;
    reset_n = 1'b1;
    idle(L + 5);
    // Phase restarts at zero after reset.
    step(1'b1, 16384, 0, 1'b0, 32'h4000_0000, 2);
    step(1'b1, 16384, 0, 1'b0, 32'h4000_0000, 2);
    idle(L + 2);

    check_int("pending_outputs", due_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
